// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel divided clock and period tick,
// runtime divisor updates taking effect at period boundaries, global phase restart.
module clk_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] act_q, act_d;
  logic [NUM_CH-1:0][CNT_W-1:0] shd_q, shd_d;
  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            clk_q, clk_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  // Low until the first edge after reset, which is treated as phase 0 of every channel.
  logic                         start_q, start_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      pend_q  <= '0;
      clk_q   <= '0;
      tick_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= CNT_W'(DEFAULT_DIV);
        shd_q[i] <= CNT_W'(DEFAULT_DIV);
      end
    end else begin
      start_q <= start_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    logic              wr;
    logic [CNT_W-1:0]  eff;
    start_d = 1'b1;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    clk_d   = '0;
    tick_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel numbers match no channel and are dropped.
      wr  = cfg_we && (cfg_ch == CH_W'(i));
      eff = wr ? cfg_div : shd_q[i];
      if (sync_restart || !start_q || (act_q[i] < CNT_W'(2)) ||
          (cnt_q[i] == act_q[i] - CNT_W'(1))) begin
        // Phase 0 edge: restart, idle/every-cycle channel, or period wrap.
        act_d[i]  = eff;
        shd_d[i]  = eff;
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        shd_d[i]  = eff;
        pend_d[i] = pend_q[i] | wr;
      end

      // Outputs for the phase being entered on this edge.
      if (act_d[i] == CNT_W'(1)) begin
        tick_d[i] = 1'b1;
      end else if (act_d[i] != '0) begin
        clk_d[i]  = {1'b0, cnt_d[i]} < (({1'b0, act_d[i]} + (CNT_W+1)'(1)) >> 1);
        tick_d[i] = (cnt_d[i] == act_d[i] - CNT_W'(1));
      end
    end
  end

  assign div_clk     = clk_q;
  assign tick        = tick_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (4-channel instance plus a
// 3-channel instance used to probe out-of-range channel writes).
module tb_clk_div_multi;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic        cfg_we_s;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        sync_restart;
  logic [3:0]  div_clk, tick, pend;
  logic [2:0]  div_clk_s, tick_s, pend_s;

  int n_tests;
  int n_fail;

  clk_div_multi #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .sync_restart(sync_restart), .div_clk(div_clk), .tick(tick), .cfg_pending(pend)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_s), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .sync_restart(sync_restart), .div_clk(div_clk_s), .tick(tick_s), .cfg_pending(pend_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic       e2, e5;
    logic [6:0] exp_c, exp_t;
    int         first_tick, n_ticks;
    logic       clk_hi_last, clk_lo_first;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_we_s = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    sync_restart = 1'b0;

    // Reset values and default D=2 on every channel
    do_reset();
    chk("rst_div_clk", 32'(div_clk), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_pending", 32'(pend), 32'h0);
    chk("rst_small_div_clk", 32'(div_clk_s), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("dflt_div_clk", 32'(div_clk), (k % 2 == 0) ? 32'hf : 32'h0);
      chk("dflt_tick", 32'(tick), (k % 2 == 1) ? 32'hf : 32'h0);
    end

    // Odd divisor on ch1, aligned by restart
    do_reset();
    step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    step();
    chk("odd_pending", 32'(pend), 32'h2);
    cfg_we = 1'b0;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("odd_pending_clr", 32'(pend), 32'h0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      e2 = (k % 2 == 0);
      e5 = (k % 5 < 3);
      chk("odd_div_clk", 32'(div_clk), 32'({e2, e2, e5, e2}));
      e2 = (k % 2 == 1);
      e5 = (k % 5 == 4);
      chk("odd_tick", 32'(tick), 32'({e2, e2, e5, e2}));
    end

    // Boundary update: ch0 D=4 -> D=6 written at phase 1
    do_reset();
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
    step();
    cfg_we = 1'b0;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("bnd_k0_clk", 32'(div_clk[0]), 32'h1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd6;
    step();
    cfg_we = 1'b0;
    chk("bnd_k1_pend", 32'(pend), 32'h1);
    chk("bnd_k1_clk", 32'(div_clk[0]), 32'h1);
    step();
    chk("bnd_k2_pend", 32'(pend), 32'h1);
    chk("bnd_k2_clk", 32'(div_clk[0]), 32'h0);
    step();
    chk("bnd_k3_pend", 32'(pend), 32'h1);
    chk("bnd_k3_tick", 32'(tick[0]), 32'h1);
    exp_c = 7'b1000111;
    exp_t = 7'b0100000;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) chk("bnd_wrap_pend", 32'(pend), 32'h0);
      chk("bnd_new_clk", 32'(div_clk[0]), 32'(exp_c[i]));
      chk("bnd_new_tick", 32'(tick[0]), 32'(exp_t[i]));
    end

    // Disable ch2 at the boundary, then re-enable with D=3
    do_reset();
    step();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
    step();
    cfg_we = 1'b0;
    chk("dis_pend", 32'(pend), 32'h4);
    chk("dis_k1_tick", 32'(tick), 32'hf);
    step();
    chk("dis_k2_div_clk", 32'(div_clk), 32'hb);
    chk("dis_k2_pend", 32'(pend), 32'h0);
    step();
    chk("dis_k3_tick", 32'(tick), 32'hb);
    chk("dis_k3_div_clk", 32'(div_clk), 32'h0);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd3;
    step();
    cfg_we = 1'b0;
    chk("en_k0_clk", 32'(div_clk[2]), 32'h1);
    chk("en_k0_pend", 32'(pend), 32'h0);
    step();
    chk("en_k1_clk", 32'(div_clk[2]), 32'h1);
    chk("en_k1_pend", 32'(pend), 32'h0);
    step();
    chk("en_k2_clk", 32'(div_clk[2]), 32'h0);
    chk("en_k2_tick", 32'(tick[2]), 32'h1);
    step();
    chk("en_k3_clk", 32'(div_clk[2]), 32'h1);

    // Restart with simultaneous write; out-of-range channel on 3-ch instance
    do_reset();
    step();
    cfg_we = 1'b1; cfg_we_s = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd8;
    step();
    cfg_we = 1'b0; cfg_we_s = 1'b0;
    chk("rs_pend", 32'(pend), 32'h8);
    chk("oor_pend", 32'(pend_s), 32'h0);
    step();
    chk("oor_div_clk", 32'(div_clk_s), 32'h7);
    chk("rs_ch3_wrap", 32'(div_clk), 32'hf);
    step();
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
    step();
    chk("rs_pend0", 32'(pend), 32'h1);
    chk("rs_mid_div_clk", 32'(div_clk), 32'h8);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd2;
    sync_restart = 1'b1;
    step();
    cfg_we = 1'b0;
    sync_restart = 1'b0;
    chk("rs_k0_div_clk", 32'(div_clk), 32'hf);
    chk("rs_k0_tick", 32'(tick), 32'h0);
    chk("rs_k0_pend", 32'(pend), 32'h0);
    step();
    chk("rs_k1_div_clk", 32'(div_clk), 32'h1);
    chk("rs_k1_tick", 32'(tick), 32'he);
    step();
    chk("rs_k2_div_clk", 32'(div_clk), 32'he);
    chk("rs_k2_tick", 32'(tick), 32'h0);
    sync_restart = 1'b1;
    step();
    step();
    chk("hold_div_clk", 32'(div_clk), 32'hf);
    chk("hold_tick", 32'(tick), 32'h0);

    // Async reset between edges discards a pending shadow
    sync_restart = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    step();
    cfg_we = 1'b0;
    chk("ar_pend_before", 32'(pend), 32'h2);
    rst = 1'b1;
    #2;
    chk("ar_div_clk", 32'(div_clk), 32'h0);
    chk("ar_tick", 32'(tick), 32'h0);
    chk("ar_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    step();
    chk("ar_k0_div_clk", 32'(div_clk), 32'hf);
    step();
    chk("ar_k1_div_clk", 32'(div_clk), 32'h0);
    chk("ar_k1_tick", 32'(tick), 32'hf);

    // D=1 on ch1: tick every cycle, also wins while restart is held
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd1;
    step();
    cfg_we = 1'b0;
    chk("d1_k2_div_clk", 32'(div_clk), 32'hd);
    chk("d1_k2_tick", 32'(tick), 32'h2);
    chk("d1_k2_pend", 32'(pend), 32'h0);
    step();
    chk("d1_k3_tick", 32'(tick), 32'hf);
    step();
    chk("d1_k4_tick", 32'(tick), 32'h2);
    sync_restart = 1'b1;
    step();
    step();
    chk("d1_hold_div_clk", 32'(div_clk), 32'hd);
    chk("d1_hold_tick", 32'(tick), 32'h2);

    // Max divisor on ch0, loaded through a simultaneous restart
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'hffff;
    step();
    cfg_we = 1'b0;
    sync_restart = 1'b0;
    chk("max_k0_clk", 32'(div_clk[0]), 32'h1);
    chk("max_k0_tick", 32'(tick[0]), 32'h0);
    first_tick = -1;
    n_ticks = 0;
    clk_hi_last = 1'b0;
    clk_lo_first = 1'b1;
    for (int i = 1; i <= 65534; i++) begin
      step();
      if (tick[0]) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (i == 32767) clk_hi_last = div_clk[0];
      if (i == 32768) clk_lo_first = div_clk[0];
    end
    chk("max_tick_count", 32'(n_ticks), 32'd1);
    chk("max_tick_phase", 32'(first_tick), 32'd65534);
    chk("max_clk_hi_last", 32'(clk_hi_last), 32'h1);
    chk("max_clk_lo_first", 32'(clk_lo_first), 32'h0);
    step();
    chk("max_wrap_clk", 32'(div_clk[0]), 32'h1);
    chk("max_wrap_tick", 32'(tick[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
